// File: rtl/key_schedule.sv
// key_schedule: AES-128/192/256 key expansion, one 128-bit round key per cycle.
module key_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key_in,
  input  logic [1:0]   switch,
  output logic [127:0] round_key,
  output logic         key_valid,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
  localparam logic [79:0] RCON = 80'h01020408102040801b36;
  typedef enum logic {IDLE, GEN} state_t;
  state_t        state;
  logic [255:0]  key;
  logic [1:0]    sz;
  logic [3:0]    r, nr, rc_j;
  logic [5:0]    nk, idx;
  logic [2:0]    off, p;
  logic [3:0]    need, rot;
  logic [31:0]   hist [8];
  logic [31:0]   pre [5];
  logic [31:0]   w [5];
  logic [31:0]   sub_in, sw, rot_sw;
  function automatic logic [31:0] sub_word(input logic [31:0] x);
    logic [31:0] o;
    o = '0;
    for (int b = 0; b < 4; b++) o[8*b +: 8] = SBOX[2047 - 8*x[8*b +: 8] -: 8];
    return o;
  endfunction
  function automatic logic [5:0] mod_nk(input logic [5:0] i, input logic [1:0] s);
    return s == 2'd0 ? {4'd0, i[1:0]} : s == 2'd1 ? i % 6'd6 : {3'd0, i[2:0]};
  endfunction
  function automatic logic [5:0] div_nk(input logic [5:0] i, input logic [1:0] s);
    return s == 2'd0 ? {2'd0, i[5:2]} : s == 2'd1 ? i / 6'd6 : {3'd0, i[5:3]};
  endfunction
  assign nk  = sz == 2'd0 ? 6'd4 : sz == 2'd1 ? 6'd6 : 6'd8;
  assign nr  = sz == 2'd0 ? 4'd10 : sz == 2'd1 ? 4'd12 : 4'd14;
  assign off = sz == 2'd0 ? 3'd4 : sz == 2'd1 ? 3'd2 : 3'd0;
  // pre[] is the group without S-box terms; it only feeds the single SubWord input,
  // which is always taken before the one position in the group that needs it.
  always_comb begin
    need = '0;
    rot = '0;
    p = '0;
    rc_j = '0;
    idx = '0;
    pre[0] = hist[7];
    for (int k = 0; k < 4; k++) begin
      idx = {r, 2'b00} + 6'(k);
      rot[k] = idx >= nk && mod_nk(idx, sz) == 6'd0;
      need[k] = rot[k] || (idx >= nk && sz == 2'd2 && idx[2:0] == 3'd4);
      if (rot[k]) rc_j = 4'(div_nk(idx, sz) - 6'd1);
      if (need[k]) p = 3'(k);
      pre[k+1] = idx < nk ? key[255 - 32*idx[2:0] -: 32] : hist[3'(k) + off] ^ pre[k];
    end
    sub_in = pre[p];
    sw = sub_word(sub_in);
    rot_sw = {sw[23:0], sw[31:24]} ^ {RCON[79 - 8*rc_j -: 8], 24'd0};
    w[0] = hist[7];
    for (int k = 0; k < 4; k++) begin
      idx = {r, 2'b00} + 6'(k);
      w[k+1] = idx < nk ? key[255 - 32*idx[2:0] -: 32]
                        : hist[3'(k) + off] ^ (rot[k] ? rot_sw : need[k] ? sw : w[k]);
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      key <= '0;
      sz <= '0;
      r <= '0;
      hist <= '{default: '0};
      round_key <= '0;
      round_idx <= '0;
      key_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (state == IDLE) begin
      key_valid <= 1'b0;
      done <= 1'b0;
      busy <= start;
      if (start) begin
        key <= key_in;
        sz <= switch[1] ? 2'd2 : switch;
        r <= '0;
        state <= GEN;
      end
    end else begin
      round_key <= {w[1], w[2], w[3], w[4]};
      round_idx <= r;
      key_valid <= 1'b1;
      busy <= 1'b1;
      done <= r == nr;
      hist <= '{hist[4], hist[5], hist[6], hist[7], w[1], w[2], w[3], w[4]};
      r <= r + 4'd1;
      if (r == nr) state <= IDLE;
    end
endmodule

// File: tb/tb_key_schedule.sv
// tb_key_schedule: randomized and known-answer checks of key_schedule against a FIPS-197 model.
module tb_key_schedule;
  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [255:0] key_in = '0;
  logic [1:0]   switch = '0;
  logic [127:0] round_key;
  logic         key_valid, busy, done;
  logic [3:0]   round_idx;
  int checks = 0, errors = 0;
  logic [7:0]   sb [256];
  logic [31:0]  mw [60];
  int           m_nr;
  logic [127:0] gk [16];
  int           gi [16];
  logic         gd [16], gb [16];
  int           n_got, lat;

  key_schedule dut (.clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in), .switch(switch),
                    .round_key(round_key), .key_valid(key_valid), .round_idx(round_idx),
                    .busy(busy), .done(done));

  always #5 clk = ~clk;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] q = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) q = q ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return q;
  endfunction

  // S-box derived from the GF(2^8) inverse and the affine map, not from a table
  task automatic build_sbox();
    logic [7:0] inv;
    logic [15:0] d;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      d = {inv, inv};
      sb[x] = inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  task automatic model(input logic [255:0] k, input logic [1:0] s);
    int nk;
    logic [31:0] t;
    logic [7:0] rc;
    nk = s == 2'd0 ? 4 : s == 2'd1 ? 6 : 8;
    m_nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4 * (m_nr + 1); i++) begin
      if (i < nk) mw[i] = k[255 - 32*i -: 32];
      else begin
        t = mw[i-1];
        if (i % nk == 0) begin
          t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk == 8 && i % 8 == 4) t = subw(t);
        mw[i] = mw[i-nk] ^ t;
      end
    end
  endtask

  function automatic logic [127:0] mkey(input int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic launch(input logic [255:0] k, input logic [1:0] s);
    start = 1'b1;
    key_in = k;
    switch = s;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic collect();
    n_got = 0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (key_valid) begin
        if (lat < 0) lat = c;
        if (n_got < 16) begin
          gk[n_got] = round_key;
          gi[n_got] = int'(round_idx);
          gd[n_got] = done;
          gb[n_got] = busy;
        end
        n_got++;
        if (done) break;
      end else if (n_got > 0) break;
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    key_in = rand_key();
    repeat (3) @(negedge clk);
    checks++;
    if (round_key !== '0 || round_idx !== 4'd0 || key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got key=%h idx=%0d v=%b b=%b d=%b want all zero",
               round_key, round_idx, key_valid, busy, done);
    end
    start = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_known(input logic [255:0] k, input logic [1:0] s, input logic [127:0] r1,
                            input logic [127:0] mask, input logic [127:0] last);
    model(k, s);
    launch(k, s);
    collect();
    checks++;
    if (n_got !== m_nr + 1) begin errors++; $display("FAIL known_count sw=%0d got %0d want %0d", s, n_got, m_nr + 1); end
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL known_latency sw=%0d got %0d want 1", s, lat); end
    for (int r = 0; r <= m_nr && r < n_got && r < 16; r++) begin
      checks++;
      if (gk[r] !== mkey(r) || gi[r] !== r || gd[r] !== (r == m_nr) || gb[r] !== 1'b1) begin
        errors++;
        $display("FAIL known_round sw=%0d r=%0d got %h idx=%0d d=%b b=%b want %h idx=%0d d=%b b=1",
                 s, r, gk[r], gi[r], gd[r], gb[r], mkey(r), r, r == m_nr);
      end
    end
    checks++;
    if ((gk[1] & mask) !== r1) begin errors++; $display("FAIL known_r1 sw=%0d got %h want %h", s, gk[1] & mask, r1); end
    checks++;
    if (gk[m_nr] !== last) begin errors++; $display("FAIL known_last sw=%0d got %h want %h", s, gk[m_nr], last); end
    @(negedge clk);
    checks++;
    if (key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || round_key !== last || round_idx !== 4'(m_nr)) begin
      errors++;
      $display("FAIL idle_hold got v=%b b=%b d=%b key=%h idx=%0d want 0 0 0 %h %0d",
               key_valid, busy, done, round_key, round_idx, last, m_nr);
    end
  endtask

  task automatic test_random();
    logic [255:0] k;
    logic [1:0] s;
    for (int n = 0; n < 8; n++) begin
      k = rand_key();
      s = 2'($urandom_range(0, 3));
      model(k, s);
      launch(k, s);
      collect();
      checks++;
      if (n_got !== m_nr + 1 || lat !== 1) begin
        errors++;
        $display("FAIL rand_count n=%0d sw=%0d got %0d lat %0d want %0d lat 1", n, s, n_got, lat, m_nr + 1);
      end
      for (int r = 0; r <= m_nr && r < n_got && r < 16; r++) begin
        checks++;
        if (gk[r] !== mkey(r) || gi[r] !== r || gd[r] !== (r == m_nr)) begin
          errors++;
          $display("FAIL rand_round n=%0d sw=%0d r=%0d got %h idx=%0d d=%b want %h",
                   n, s, r, gk[r], gi[r], gd[r], mkey(r));
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_ignore_start();
    logic [255:0] k = rand_key();
    model(k, 2'b00);
    launch(k, 2'b00);
    n_got = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (key_valid) begin
        checks++;
        if (round_key !== mkey(n_got) || int'(round_idx) !== n_got || done !== (n_got == 10)) begin
          errors++;
          $display("FAIL ignore_round r=%0d got %h idx=%0d d=%b want %h", n_got, round_key, round_idx, done, mkey(n_got));
        end
        n_got++;
        if (round_idx == 4'd5) begin
          start = 1'b1;
          key_in = rand_key();
          switch = 2'b01;
        end
        if (done || n_got > 11) break;
      end else if (n_got > 0) break;
    end
    start = 1'b0;
    checks++;
    if (n_got !== 11) begin errors++; $display("FAIL ignore_count got %0d want 11", n_got); end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (key_valid !== 1'b0) begin errors++; $display("FAIL ignore_restart got valid=%b want 0", key_valid); end
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] k = rand_key();
    int found = 0;
    model(k, 2'b00);
    launch(k, 2'b00);
    for (int c = 0; c < 12 && found == 0; c++) begin
      @(negedge clk);
      if (key_valid && round_idx == 4'd3) found = 1;
    end
    checks++;
    if (found == 0 || round_key !== mkey(3)) begin
      errors++;
      $display("FAIL mid_round3 found=%0d got %h want %h", found, round_key, mkey(3));
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (round_key !== '0 || round_idx !== 4'd0 || key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_async got key=%h idx=%0d v=%b b=%b d=%b want all zero",
               round_key, round_idx, key_valid, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++;
      if (key_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL mid_quiet c=%0d got v=%b b=%b want 0 0", c, key_valid, busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] k = rand_key();
    int cc, n_done = 0;
    model(k, 2'b00);
    key_in = k;
    switch = 2'b00;
    start = 1'b1;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      cc = c % 12;
      checks++;
      if (key_valid !== (cc != 0)) begin
        errors++;
        $display("FAIL b2b_valid c=%0d got %b want %b", c, key_valid, cc != 0);
      end else if (cc != 0 && (round_key !== mkey(cc - 1) || int'(round_idx) !== cc - 1 || done !== (cc == 11))) begin
        errors++;
        $display("FAIL b2b_round c=%0d got %h idx=%0d d=%b want %h idx=%0d", c, round_key, round_idx, done, mkey(cc - 1), cc - 1);
      end
      if (done) n_done++;
    end
    start = 1'b0;
    checks++;
    if (n_done !== 3) begin errors++; $display("FAIL b2b_done_count got %0d want 3", n_done); end
    @(negedge clk);
    checks++;
    if (key_valid !== 1'b0) begin errors++; $display("FAIL b2b_stop got valid=%b want 0", key_valid); end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_known({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 2'b00,
               128'ha0fafe1788542cb123a339392a6c7605, {128{1'b1}},
               128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    test_known({192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0}, 2'b01,
               128'h62f8ead2522c6b7b0000000000000000, {{64{1'b1}}, 64'h0},
               128'he98ba06f448c773c8ecc720401002202);
    test_known(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 2'b10,
               128'h1f352c073b6108d72d9810a30914dff4, {128{1'b1}},
               128'hfe4890d1e6188d0b046df344706c631e);
    test_known(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 2'b11,
               128'h1f352c073b6108d72d9810a30914dff4, {128{1'b1}},
               128'hfe4890d1e6188d0b046df344706c631e);
    test_random();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/key_schedule.md
KEY_SCHEDULE -- requirements
Module: key_schedule

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 start  input  1  request expansion of key_in; sampled only while idle.
REQ-004 key_in  input  256  cipher key, MSB-aligned; word w0 = key_in[255:224]; 128-bit key in [255:128], 192-bit in [255:64].
REQ-005 switch  input  2  key size: 2'b00 = 128 (Nk=4, Nr=10), 2'b01 = 192 (Nk=6, Nr=12), 2'b10/2'b11 = 256 (Nk=8, Nr=14); sampled with start.
REQ-006 round_key  output  128  current round key {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in [127:96].
REQ-007 key_valid  output  1  round_key and round_idx valid this cycle.
REQ-008 round_idx  output  4  round number r of round_key, 0..Nr.
REQ-009 busy  output  1  high from the cycle after start acceptance through the cycle carrying round Nr.
REQ-010 done  output  1  one-cycle pulse coincident with round Nr.

Function
REQ-011 States: IDLE, GEN; IDLE->GEN on start; GEN->IDLE after emitting round Nr.
REQ-012 Start acceptance in IDLE latches key_in, Nk and Nr; key_in/switch changes during GEN have no effect.
REQ-013 start asserted during GEN is ignored (not queued).
REQ-014 Start accepted at edge T -> round 0 visible after edge T+1; round r after edge T+1+r; one round key per cycle, no gaps.
REQ-015 Word rule per FIPS-197: w[i] = key word i for i < Nk; otherwise w[i] = w[i-Nk] ^ temp, where temp = SubWord(RotWord(w[i-1])) ^ Rcon[i/Nk] if i mod Nk = 0; SubWord(w[i-1]) if Nk = 8 and i mod 8 = 4; else w[i-1].
REQ-016 Each GEN cycle computes the four words 4r..4r+3 combinationally; words of index < Nk come from the latched key, never computed (covers 192-bit round 1 = {w4, w5 from key, w6, w7 computed}).
REQ-017 History: 8-word register holding w[4r-8..4r-1]; updated with the group just emitted.
REQ-018 One SubWord per cycle (4 FIPS-197 S-box byte lookups) suffices for all key sizes.
REQ-019 Rcon sequence 01,02,04,08,10,20,40,80,1B,36 in the most significant byte, indexed by i/Nk (1-based); all XORs are 32-bit, no carries.
REQ-020 round_key, round_idx, key_valid, busy and done are registered outputs.
REQ-021 In IDLE: key_valid = 0, busy = 0, done = 0; round_key and round_idx hold the last emitted values.
REQ-022 Back-to-back: start may be accepted in the first IDLE cycle after done; the new round 0 follows with exactly one idle cycle in between.
REQ-023 switch = 2'b11 behaves identically to 2'b10.

Reset
REQ-024 rst_n low forces IDLE immediately; round_key = 0, round_idx = 0, key_valid = 0, busy = 0, done = 0; key latch and history cleared.
REQ-025 Reset during GEN aborts expansion; no further key_valid until a new start after rst_n deasserts.
REQ-026 The first rising edge with rst_n high may accept start.

Verification
REQ-027 AES-128, key 2b7e151628aed2a6abf7158809cf4f3c -> round 0 = key; round 1 = a0fafe1788542cb123a339392a6c7605; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6 with done; 11 consecutive key_valid cycles.
REQ-028 AES-192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, switch = 01 -> round 1 upper 64 bits = 62f8ead2522c6b7b; round 12 = e98ba06f448c773c8ecc720401002202; 13 valid cycles.
REQ-029 AES-256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, switch = 10 and 11 -> round 1 = 1f352c073b6108d72d9810a30914dff4; round 14 = fe4890d1e6188d0b046df344706c631e.
REQ-030 start pulsed and key_in changed at round 5 of an AES-128 run -> sequence unchanged, completes at round 10; no restart.
REQ-031 rst_n asserted at round 3 -> all outputs 0 asynchronously; after release with no start, key_valid stays 0 for 20 cycles.
REQ-032 start held high continuously with AES-128 -> runs of 11 keys separated by exactly one idle cycle; done once per run.
